// File: rtl/input_pkg.sv
// Shared register offsets, read-select type and counter-width helper for the
// button input peripheral.
package input_pkg;

    localparam logic [11:0] LEVEL_OFS   = 12'd0;
    localparam logic [11:0] PRESS_OFS   = 12'd1;
    localparam logic [11:0] RELEASE_OFS = 12'd2;

    localparam int REG_W = 16;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_LEVEL,
        SEL_PRESS,
        SEL_RELEASE
    } reg_sel_e;

    // Width of a counter that must hold values 0..max_count (never below 1 bit).
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Single-bit two-flop synchroniser plus debounce counter. rise/fall pulse in
// the same cycle the debounced state is updated.
module button_debounce
    import input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 125000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic state,
    output logic rise,
    output logic fall
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             state_q;
    logic             state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any cycle where the synchronised input agrees with state restarts the count.
    always_comb begin
        accept  = (sync2_q != state_q) && (cnt_q == CNT_LAST);
        state_d = state_q;
        cnt_d   = cnt_q;
        if (sync2_q == state_q) begin
            cnt_d = '0;
        end else if (accept) begin
            state_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign state = state_q;
    assign rise  = accept & sync2_q;
    assign fall  = accept & ~sync2_q;

endmodule

// File: rtl/button_input_controller.sv
// Debounced push-button peripheral with level / sticky press / sticky release
// registers. Define BUTTON_INPUT_AUTOREPEAT_EN to add hold-to-repeat press events.
module button_input_controller
    import input_pkg::*;
#(
    parameter int NUM_BUTTONS     = 4,
    parameter int BASE_INDEX      = 0,
    parameter int DEBOUNCE_CYCLES = 125000
`ifdef BUTTON_INPUT_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 2500000
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] buttons,
    input  logic [11:0]            register_index,
    input  logic                   register_read,
    output logic [REG_W-1:0]       register_read_value,
    output logic                   register_read_hit,
    output logic [NUM_BUTTONS-1:0] button_state
);

    localparam logic [11:0] LEVEL_IDX   = 12'(BASE_INDEX) + LEVEL_OFS;
    localparam logic [11:0] PRESS_IDX   = 12'(BASE_INDEX) + PRESS_OFS;
    localparam logic [11:0] RELEASE_IDX = 12'(BASE_INDEX) + RELEASE_OFS;

    logic [NUM_BUTTONS-1:0] state_w;
    logic [NUM_BUTTONS-1:0] rise_w;
    logic [NUM_BUTTONS-1:0] fall_w;
    logic [NUM_BUTTONS-1:0] repeat_w;

    logic [NUM_BUTTONS-1:0] press_q;
    logic [NUM_BUTTONS-1:0] press_d;
    logic [NUM_BUTTONS-1:0] release_q;
    logic [NUM_BUTTONS-1:0] release_d;
    logic [REG_W-1:0]       rd_value_q;
    logic [REG_W-1:0]       rd_value_d;
    logic                   rd_hit_q;
    logic                   rd_hit_d;
    reg_sel_e               sel;

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .raw   (buttons[g]),
            .state (state_w[g]),
            .rise  (rise_w[g]),
            .fall  (fall_w[g])
        );
    end

`ifdef BUTTON_INPUT_AUTOREPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = cnt_width(HOLD_MAX);

    // Down-counter per button: loaded on press, fires at zero and reloads with the period.
    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_rep
        logic [HOLD_W-1:0] hold_q;
        logic [HOLD_W-1:0] hold_d;
        logic              rep;

        always_comb begin
            hold_d = hold_q;
            rep    = 1'b0;
            if (rise_w[g]) begin
                hold_d = HOLD_W'(REPEAT_DELAY - 1);
            end else if (!state_w[g]) begin
                hold_d = '0;
            end else if (hold_q == '0) begin
                rep    = 1'b1;
                hold_d = HOLD_W'(REPEAT_PERIOD - 1);
            end else begin
                hold_d = hold_q - HOLD_W'(1);
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                hold_q <= '0;
            end else begin
                hold_q <= hold_d;
            end
        end

        assign repeat_w[g] = rep;
    end
`else
    assign repeat_w = '0;
`endif

    always_comb begin
        sel = SEL_NONE;
        if (register_read) begin
            unique case (register_index)
                LEVEL_IDX:   sel = SEL_LEVEL;
                PRESS_IDX:   sel = SEL_PRESS;
                RELEASE_IDX: sel = SEL_RELEASE;
                default:     sel = SEL_NONE;
            endcase
        end
    end

    // Read data captures pre-event values; a new event in the clearing cycle survives.
    always_comb begin
        rd_value_d = rd_value_q;
        rd_hit_d   = rd_hit_q;
        if (register_read) begin
            rd_hit_d   = (sel != SEL_NONE);
            rd_value_d = '0;
            unique case (sel)
                SEL_LEVEL:   rd_value_d[NUM_BUTTONS-1:0] = state_w;
                SEL_PRESS:   rd_value_d[NUM_BUTTONS-1:0] = press_q;
                SEL_RELEASE: rd_value_d[NUM_BUTTONS-1:0] = release_q;
                default:     rd_value_d = '0;
            endcase
        end
        press_d   = (press_q   & ~{NUM_BUTTONS{sel == SEL_PRESS}})   | rise_w | repeat_w;
        release_d = (release_q & ~{NUM_BUTTONS{sel == SEL_RELEASE}}) | fall_w;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press_q    <= '0;
            release_q  <= '0;
            rd_value_q <= '0;
            rd_hit_q   <= 1'b0;
        end else begin
            press_q    <= press_d;
            release_q  <= release_d;
            rd_value_q <= rd_value_d;
            rd_hit_q   <= rd_hit_d;
        end
    end

    assign register_read_value = rd_value_q;
    assign register_read_hit   = rd_hit_q;
    assign button_state        = state_w;

endmodule
